hyperram_cmd_sequencer: RTL and testbench
=========================================

Name: hyperram_cmd_sequencer

Overview:
- Upstream stage of the HyperRAM controller's s0 port.
- Accepts Avalon-MM pipelined/burst traffic from the system interconnect and queues it in a command FIFO.
- Expands bursts into single-word accesses and issues each one as a one-cycle read/write strobe, with the inter-strobe spacing the controller's edge detector requires.
- Returns read data to the host and paces writes, because s0 gives no write acknowledge.

Parameters:
- CMD_DEPTH, 4, command FIFO entries (power of 2, ≥2)
- MIN_GAP, 3, cycles strobes held low between consecutive accesses (≥2)
- WR_WAIT, 48, cycles waited after a write strobe before the access is considered done
- TIMEOUT, 1023, max cycles waiting for m_readdatavalid (10-bit counter)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- h_address  in  22  host word address
- h_read  in  1  host read request
- h_write  in  1  host write request/beat
- h_writedata  in  32  host write data
- h_burstcount  in  4  burst length, sampled on first beat; 0 treated as 1
- h_waitrequest  out  1  host stall
- h_readdata  out  32  read data to host
- h_readdatavalid  out  1  read data valid, 1 cycle per word
- m_address  out  22  to controller s0_address
- m_read  out  1  to s0_read
- m_write  out  1  to s0_write
- m_writedata  out  32  to s0_writedata
- m_readdata  in  32  from s0_readdata
- m_readdatavalid  in  1  from s0_readdatavalid
- busy  out  1  FIFO non-empty or FSM not IDLE
- err_timeout  out  1  sticky: a read timed out
- err_proto  out  1  sticky: h_read and h_write asserted together

Behaviour:
Reset:
- rst is synchronous, active-high; clock is clk.
- All outputs go to 0 on reset, except h_waitrequest = 1 while rst is high and 0 afterwards.
- FIFO is emptied, FSM goes to IDLE, error flags are cleared.
- A reset mid-access drops the strobes on the next edge; any late m_readdatavalid after reset is ignored.

Command FIFO:
- Entry format: {op, addr[21:0], count[3:0], data[31:0]}.
- Read: one entry per command, count = burstcount.
- Write: one entry per beat, count = 1, addr = base + beat index.
- h_waitrequest is high when the FIFO is full.
- h_waitrequest is also high for h_read while a write burst has beats still pending from the host.
- A transfer is accepted when the request is high and h_waitrequest is low.
- Simultaneous push and pop is allowed when full; the count is unchanged.

Conflicting requests:
- h_read and h_write both high → treated as a write, and err_proto is set.

FSM states: IDLE, ISSUE, WAIT_RD, WAIT_WR, GAP.
- IDLE: if the FIFO is non-empty, load the head into working registers (cur_addr, remaining, data) and go to ISSUE.
- ISSUE:
  - Assert exactly one of m_read/m_write for exactly 1 cycle.
  - m_address and m_writedata are driven from ISSUE until leaving WAIT_*, and stay stable throughout.
  - Next state is WAIT_RD or WAIT_WR.
- WAIT_RD:
  - On m_readdatavalid, register m_readdata → h_readdata with h_readdatavalid high the next cycle.
  - Latency is m_readdatavalid + 1 clk.
  - If TIMEOUT cycles elapse without m_readdatavalid, return 32'hDEADBEEF as valid data and set err_timeout.
  - Then go to GAP.
- WAIT_WR: count WR_WAIT cycles, then go to GAP.
- GAP:
  - Hold strobes low for MIN_GAP cycles.
  - If remaining > 1: decrement remaining, set cur_addr = cur_addr + 1 (22-bit, 3FFFFF wraps to 000000), go to ISSUE.
  - Otherwise: pop the FIFO and go to IDLE.

Ordering:
- Read data returns in command order.
- Host bursts never interleave at the strobe level.

Test Plan:
- Single read, addr 0x000010; controller model returns 0x12345678 4 cycles after strobe → m_read high exactly 1 cycle; h_readdata = 0x12345678 one cycle after m_readdatavalid; busy low after MIN_GAP.
- Read burst of 4 at 0x3FFFFE → m_address sequence 3FFFFE, 3FFFFF, 000000, 000001; every strobe separated by ≥3 low cycles; 4 h_readdatavalid pulses in order.
- Write burst of 3 at 0x000100 with data A0/A1/A2 → three m_write pulses at 100/101/102 with matching m_writedata, spaced by ≥ WR_WAIT + MIN_GAP cycles.
- Flood 6 single writes back-to-back → h_waitrequest high after 4 accepted; all 6 issued in order; no beat lost.
- Read with no m_readdatavalid → after 1023 cycles h_readdata = 0xDEADBEEF, err_timeout = 1 and stays set until rst.
- Assert rst during WAIT_WR, and separately assert h_read and h_write together → on rst, strobes and busy are 0 the next cycle, FIFO empty, late m_readdatavalid produces no h_readdatavalid; on simultaneous h_read/h_write, err_proto = 1 and the request executes as a write.

Source files
------------

// File: rtl/hyperram_cmd_sequencer.sv
// hyperram_cmd_sequencer
// Upstream stage of the HyperRAM controller's s0 port. It accepts Avalon-MM
// pipelined/burst traffic from the host, queues it in a small command FIFO,
// and expands each command into single-word accesses. Each access is a
// one-cycle m_read/m_write strobe, and strobes are spaced so the
// controller's edge detector sees a clean low period between them. Read
// data is returned in order. Writes are paced by a fixed wait because s0
// gives no write acknowledge.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   h_*                host-side Avalon-MM slave
//                      (address, read, write, writedata, burstcount,
//                       waitrequest, readdata, readdatavalid)
//   m_*                controller s0 master
//                      (address, read, write, writedata, readdata,
//                       readdatavalid)
//   busy               FIFO non-empty or FSM not idle
//   err_timeout        sticky: a read got no m_readdatavalid in time
//   err_proto          sticky: h_read and h_write were seen together
module hyperram_cmd_sequencer #(
  parameter int CMD_DEPTH = 4,
  parameter int MIN_GAP   = 3,
  parameter int WR_WAIT   = 48,
  parameter int TIMEOUT   = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [21:0] h_address,
  input  logic        h_read,
  input  logic        h_write,
  input  logic [31:0] h_writedata,
  input  logic [3:0]  h_burstcount,
  output logic        h_waitrequest,
  output logic [31:0] h_readdata,
  output logic        h_readdatavalid,
  output logic [21:0] m_address,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  input  logic        m_readdatavalid,
  output logic        busy,
  output logic        err_timeout,
  output logic        err_proto
);

  localparam int PW = $clog2(CMD_DEPTH);
  localparam logic [PW:0] DEPTH_V  = (PW+1)'(CMD_DEPTH);
  localparam logic [9:0]  TO_LAST  = 10'(TIMEOUT - 1);
  localparam logic [9:0]  WW_LAST  = 10'(WR_WAIT - 1);
  localparam logic [9:0]  GAP_LAST = 10'(MIN_GAP - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RD, WAIT_WR, GAP} state_t;

  // Entry layout: {op[58], addr[57:36], count[35:32], data[31:0]}, op=1 is write
  logic [58:0]   fifo_mem [CMD_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   fifo_cnt;
  logic          fifo_full, fifo_empty, push, pop;
  logic [58:0]   push_entry, head;

  logic [3:0]    first_count;
  logic [3:0]    wr_left;
  logic [3:0]    wr_idx;
  logic [21:0]   wr_base;

  state_t        state;
  logic          cur_op;
  logic [21:0]   cur_addr;
  logic [3:0]    remaining;
  logic [9:0]    timer;

  assign first_count = (h_burstcount == 4'd0) ? 4'd1 : h_burstcount;
  assign fifo_full   = (fifo_cnt == DEPTH_V);
  assign fifo_empty  = (fifo_cnt == '0);
  assign head        = fifo_mem[rd_ptr];
  assign pop         = (state == GAP) && (timer == GAP_LAST) && (remaining <= 4'd1);

  // A full FIFO still accepts when the head is leaving this cycle. A read
  // must not slip between beats of a write burst, so it stalls until the
  // burst's last beat is in. h_write wins when both requests are high.
  assign h_waitrequest = rst | (fifo_full & ~pop) | (h_read & ~h_write & (wr_left != 4'd0));
  assign push          = (h_read | h_write) & ~h_waitrequest;
  assign busy          = ~fifo_empty | (state != IDLE);

  // Write bursts become one entry per beat, addressed base + beat index
  always_comb begin
    push_entry = '0;
    if (h_write) begin
      if (wr_left != 4'd0)
        push_entry = {1'b1, wr_base + 22'(wr_idx), 4'd1, h_writedata};
      else
        push_entry = {1'b1, h_address, 4'd1, h_writedata};
    end else begin
      push_entry = {1'b0, h_address, first_count, 32'd0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_left <= '0;
      wr_idx  <= '0;
      wr_base <= '0;
    end else if (push && h_write) begin
      if (wr_left == 4'd0) begin
        wr_base <= h_address;
        wr_idx  <= 4'd1;
        wr_left <= first_count - 4'd1;
      end else begin
        wr_idx  <= wr_idx + 4'd1;
        wr_left <= wr_left - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // The head stays in the FIFO until its last word completes, so a full
  // FIFO keeps back-pressuring the host during the whole access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cur_op          <= 1'b0;
      cur_addr        <= '0;
      remaining       <= '0;
      timer           <= '0;
      m_address       <= '0;
      m_read          <= 1'b0;
      m_write         <= 1'b0;
      m_writedata     <= '0;
      h_readdata      <= '0;
      h_readdatavalid <= 1'b0;
      err_timeout     <= 1'b0;
      err_proto       <= 1'b0;
    end else begin
      h_readdatavalid <= 1'b0;
      if (h_read && h_write)
        err_proto <= 1'b1;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            cur_op      <= head[58];
            cur_addr    <= head[57:36];
            remaining   <= head[35:32];
            m_address   <= head[57:36];
            m_writedata <= head[31:0];
            m_read      <= ~head[58];
            m_write     <= head[58];
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          m_read  <= 1'b0;
          m_write <= 1'b0;
          timer   <= '0;
          state   <= cur_op ? WAIT_WR : WAIT_RD;
        end
        WAIT_RD: begin
          if (m_readdatavalid) begin
            h_readdata      <= m_readdata;
            h_readdatavalid <= 1'b1;
            timer           <= '0;
            state           <= GAP;
          end else if (timer == TO_LAST) begin
            h_readdata      <= 32'hDEADBEEF;
            h_readdatavalid <= 1'b1;
            err_timeout     <= 1'b1;
            timer           <= '0;
            state           <= GAP;
          end else begin
            timer <= timer + 10'd1;
          end
        end
        WAIT_WR: begin
          if (timer == WW_LAST) begin
            timer <= '0;
            state <= GAP;
          end else begin
            timer <= timer + 10'd1;
          end
        end
        GAP: begin
          if (timer == GAP_LAST) begin
            timer <= '0;
            if (remaining > 4'd1) begin
              // Next word of a read burst; the 22-bit address wraps naturally
              remaining <= remaining - 4'd1;
              cur_addr  <= cur_addr + 22'd1;
              m_address <= cur_addr + 22'd1;
              m_read    <= ~cur_op;
              m_write   <= cur_op;
              state     <= ISSUE;
            end else begin
              state <= IDLE;
            end
          end else begin
            timer <= timer + 10'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hyperram_cmd_sequencer.sv
// tb_hyperram_cmd_sequencer
// Self-checking bench for hyperram_cmd_sequencer. Host commands push the
// expected strobes and read data into scoreboard queues. A negedge monitor
// pops and compares them as the DUT strobes s0 or returns data. A small
// controller model answers reads four cycles after each m_read strobe.
`timescale 1ns/1ps
module tb_hyperram_cmd_sequencer;

  localparam int MIN_GAP = 3;
  localparam int WR_WAIT = 48;

  typedef struct packed {
    logic        op;
    logic [21:0] addr;
    logic [31:0] data;
  } strobe_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [21:0] h_address;
  logic        h_read, h_write;
  logic [31:0] h_writedata;
  logic [3:0]  h_burstcount;
  logic        h_waitrequest;
  logic [31:0] h_readdata;
  logic        h_readdatavalid;
  logic [21:0] m_address;
  logic        m_read, m_write;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;
  logic        m_readdatavalid;
  logic        busy, err_timeout, err_proto;

  logic        model_rdv = 1'b0, manual_rdv = 1'b0;
  logic [31:0] model_rdata = '0, manual_rdata = '0;
  logic        ctrl_silent = 1'b0;

  strobe_t     exp_strobe[$];
  logic [31:0] exp_rd[$];

  int checks = 0;
  int errors = 0;
  int last_stalls = 0;
  int rdv_count = 0;
  int cycle = 0;
  int last_rdv_cycle = 0;
  int low_run = 0;
  logic first_strobe = 1'b1;
  logic prev_was_wr = 1'b0;
  logic prev_strobe = 1'b0;

  assign m_readdatavalid = model_rdv | manual_rdv;
  assign m_readdata      = model_rdv ? model_rdata : manual_rdata;

  always #5 clk = ~clk;

  hyperram_cmd_sequencer #(
    .CMD_DEPTH(4), .MIN_GAP(MIN_GAP), .WR_WAIT(WR_WAIT), .TIMEOUT(1023)
  ) dut (
    .clk(clk), .rst(rst),
    .h_address(h_address), .h_read(h_read), .h_write(h_write),
    .h_writedata(h_writedata), .h_burstcount(h_burstcount),
    .h_waitrequest(h_waitrequest), .h_readdata(h_readdata),
    .h_readdatavalid(h_readdatavalid),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid),
    .busy(busy), .err_timeout(err_timeout), .err_proto(err_proto)
  );

  function automatic logic [31:0] memWord(input logic [21:0] a);
    if (a == 22'h000010) return 32'h12345678;
    return {10'h2A5, a};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // One host beat: starts at posedge+1, holds until accepted, releases at posedge+1
  task automatic hostBeat(input logic rd, input logic wr, input logic [21:0] a,
                          input logic [31:0] d, input logic [3:0] bc);
    h_read = rd; h_write = wr; h_address = a; h_writedata = d; h_burstcount = bc;
    last_stalls = 0;
    @(negedge clk);
    while (h_waitrequest && last_stalls < 200) begin
      last_stalls++;
      @(negedge clk);
    end
    if (h_waitrequest)
      checkOutput("accept_timeout", 32'(last_stalls), 0);
    @(posedge clk); #1;
    h_read = 1'b0; h_write = 1'b0;
  endtask

  task automatic applyStimulus(input logic is_wr, input logic both, input logic [21:0] a,
                               input int n, input logic [31:0] d0);
    strobe_t s;
    for (int i = 0; i < n; i++) begin
      s.op   = is_wr;
      s.addr = a + 22'(i);
      s.data = is_wr ? d0 + 32'(i) : 32'h0;
      exp_strobe.push_back(s);
      if (!is_wr) exp_rd.push_back(ctrl_silent ? 32'hDEADBEEF : memWord(s.addr));
    end
    if (is_wr) begin
      for (int i = 0; i < n; i++)
        hostBeat(both, 1'b1, a + 22'(i), d0 + 32'(i), 4'(n));
    end else begin
      hostBeat(1'b1, 1'b0, a, 32'h0, 4'(n));
    end
  endtask

  task automatic waitIdle(input int bound);
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < bound) begin
      k++;
      @(negedge clk);
    end
    checkOutput("idle_reached", {31'b0, busy}, 0);
    @(posedge clk); #1;
  endtask

  // Controller model: answers each m_read four cycles after the strobe
  initial begin
    logic [21:0] a;
    forever begin
      @(negedge clk);
      if (!rst && m_read && !ctrl_silent) begin
        a = m_address;
        repeat (4) @(posedge clk);
        #1;
        model_rdata = memWord(a);
        model_rdv   = 1'b1;
        @(posedge clk); #1;
        model_rdv   = 1'b0;
      end
    end
  end

  // Monitor and scoreboard
  always @(negedge clk) begin
    strobe_t e;
    logic [31:0] er;
    int req;
    cycle++;
    if (rst) begin
      exp_strobe.delete();
      exp_rd.delete();
      first_strobe = 1'b1;
      low_run = 0;
      prev_strobe = 1'b0;
    end else begin
      if (m_readdatavalid) last_rdv_cycle = cycle;
      if (m_read || m_write) begin
        checkOutput("strobe_excl", {31'b0, m_read & m_write}, 0);
        checkOutput("strobe_width", {31'b0, prev_strobe}, 0);
        if (!first_strobe) begin
          req = prev_was_wr ? (WR_WAIT + MIN_GAP) : MIN_GAP;
          checkOutput("strobe_gap", (low_run >= req) ? 32'(req) : 32'(low_run), 32'(req));
        end
        if (exp_strobe.size() == 0) begin
          checkOutput("strobe_unexpected", {9'b0, m_write, m_address}, 0);
        end else begin
          e = exp_strobe.pop_front();
          checkOutput("strobe_op", {31'b0, m_write}, {31'b0, e.op});
          checkOutput("strobe_addr", {10'b0, m_address}, {10'b0, e.addr});
          if (e.op) checkOutput("strobe_wdata", m_writedata, e.data);
        end
        first_strobe = 1'b0;
        prev_was_wr  = m_write;
        low_run = 0;
      end else begin
        low_run++;
      end
      prev_strobe = m_read | m_write;
      if (h_readdatavalid) begin
        rdv_count++;
        if (exp_rd.size() == 0) begin
          checkOutput("rd_unexpected", h_readdata, 0);
        end else begin
          er = exp_rd.pop_front();
          checkOutput("rd_data", h_readdata, er);
          if (er != 32'hDEADBEEF)
            checkOutput("rd_latency", 32'(cycle - last_rdv_cycle), 1);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    int rdv_before;
    rst = 1'b1; h_read = 1'b0; h_write = 1'b0; h_address = '0;
    h_writedata = '0; h_burstcount = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_waitreq", {31'b0, h_waitrequest}, 1);
    checkOutput("rst_busy", {31'b0, busy}, 0);
    checkOutput("rst_strobes", {30'b0, m_read, m_write}, 0);
    checkOutput("rst_rdv", {31'b0, h_readdatavalid}, 0);
    checkOutput("rst_errs", {30'b0, err_timeout, err_proto}, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_waitreq", {31'b0, h_waitrequest}, 0);
    @(posedge clk); #1;

    $display("[TB] single read");
    applyStimulus(1'b0, 1'b0, 22'h000010, 1, 32'h0);
    waitIdle(200);

    $display("[TB] read burst of 4 across address wrap");
    applyStimulus(1'b0, 1'b0, 22'h3FFFFE, 4, 32'h0);
    waitIdle(400);

    $display("[TB] write burst of 3");
    applyStimulus(1'b1, 1'b0, 22'h000100, 3, 32'h000000A0);
    waitIdle(400);

    $display("[TB] flood of 6 single writes");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, 22'h000200 + 22'(i), 1, 32'h0000F000 + 32'(i));
      checkOutput("flood_stall", {31'b0, last_stalls != 0}, {31'b0, i >= 4});
    end
    waitIdle(800);

    $display("[TB] read timeout");
    ctrl_silent = 1'b1;
    applyStimulus(1'b0, 1'b0, 22'h0002A0, 1, 32'h0);
    waitIdle(1500);
    ctrl_silent = 1'b0;
    checkOutput("err_timeout_set", {31'b0, err_timeout}, 1);

    $display("[TB] simultaneous read and write");
    applyStimulus(1'b1, 1'b1, 22'h000055, 1, 32'h5555AAAA);
    @(negedge clk);
    checkOutput("err_proto_set", {31'b0, err_proto}, 1);
    @(posedge clk); #1;
    waitIdle(200);
    checkOutput("err_timeout_sticky", {31'b0, err_timeout}, 1);

    $display("[TB] reset during write wait");
    applyStimulus(1'b1, 1'b0, 22'h000300, 1, 32'hCAFE0001);
    k = 0;
    @(negedge clk);
    while (!m_write && k < 50) begin
      k++;
      @(negedge clk);
    end
    checkOutput("wr_strobe_seen", {31'b0, m_write}, 1);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_waitreq", {31'b0, h_waitrequest}, 1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_busy", {31'b0, busy}, 0);
    checkOutput("rst_mid_strobes", {30'b0, m_read, m_write}, 0);
    checkOutput("rst_mid_errs", {30'b0, err_timeout, err_proto}, 0);
    checkOutput("rst_mid_waitreq_low", {31'b0, h_waitrequest}, 0);
    @(posedge clk); #1;
    rdv_before = rdv_count;
    manual_rdata = 32'hBAD0BAD0;
    manual_rdv = 1'b1;
    @(posedge clk); #1 manual_rdv = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("late_rdv_ignored", 32'(rdv_count), 32'(rdv_before));
    @(posedge clk); #1;

    $display("[TB] read after reset");
    applyStimulus(1'b0, 1'b0, 22'h000020, 1, 32'h0);
    waitIdle(200);

    checkOutput("sb_strobe_drain", 32'(exp_strobe.size()), 0);
    checkOutput("sb_rd_drain", 32'(exp_rd.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
